// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder.
//   CLA_W / CLA_B : default operand width and lookahead block width
//   gp_t          : group generate/propagate pair
//   gp_combine    : merges a more-significant group (hi) onto a less-significant one (lo)
package cla_pkg;

  localparam int CLA_W = 16;
  localparam int CLA_B = 4;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // Standard lookahead operator: hi generates, or hi propagates a carry generated by lo.
  function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
    gp_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

endpackage

// File: rtl/cla_block.sv
// One B-bit carry-lookahead block, purely combinational.
//   i_g, i_p : per-bit generate / propagate
//   i_c_in   : carry into bit 0 of the block
//   o_gp     : group generate / propagate of the whole block
//   o_c      : carry out of each bit of the block (o_c[j] = carry out of bit j)
module cla_block
  import cla_pkg::*;
#(
  parameter int B = CLA_B
) (
  input  logic [B-1:0] i_g,
  input  logic [B-1:0] i_p,
  input  logic         i_c_in,
  output gp_t          o_gp,
  output logic [B-1:0] o_c
);

  // In-block carries and group G/P, accumulated from bit 0 upward.
  always_comb begin
    logic c_v;
    gp_t  acc_v;
    c_v   = i_c_in;
    acc_v = '{g: 1'b0, p: 1'b1};
    o_c   = '0;
    for (int j = 0; j < B; j++) begin
      c_v    = i_g[j] | (i_p[j] & c_v);
      o_c[j] = c_v;
      acc_v  = gp_combine(gp_t'({i_g[j], i_p[j]}), acc_v);
    end
    o_gp = acc_v;
  end

endmodule

// File: rtl/pipelined_cla_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshakes.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (a, b, cin, sub)
//   sub                 : 0 -> a+b+cin, 1 -> a-b (cin ignored)
//   out_valid/out_ready : result handshake (sum, cout, ovf)
// Stage 1 forms g/p and block group G/P; stage 2 runs the block lookahead,
// the in-block carries and the final sum. Results are modulo 2^W.
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int W = CLA_W,
  parameter int B = CLA_B
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int NB = (B >= 1) ? (W / B) : 1;

  if (B < 1) begin : g_bad_b
    $fatal(1, "pipelined_cla_adder: B must be >= 1");
  end else if ((W % B) != 0) begin : g_bad_w
    $fatal(1, "pipelined_cla_adder: W must be a multiple of B");
  end

  // Stage 1 state
  logic            r_s1_valid;
  logic [W-1:0]    r_b_eff;
  logic            r_cin_eff;
  logic [W-1:0]    r_g;
  logic [W-1:0]    r_p;
  gp_t  [NB-1:0]   r_gp;
  logic            r_a_msb;
  logic            r_b_msb;

  // Stage 2 state
  logic            r_out_valid;
  logic [W-1:0]    r_sum;
  logic            r_cout;
  logic            r_ovf;

  logic            w_adv1;
  logic            w_adv2;
  logic [W-1:0]    w_b_eff;
  logic            w_cin_eff;
  logic [W-1:0]    w_g;
  logic [W-1:0]    w_p;
  gp_t  [NB-1:0]   w_gp;
  logic [NB:0]     w_blk_c;
  gp_t  [NB-1:0]   w_gp_s2;
  logic [W-1:0]    w_bit_cout;
  logic [W-1:0]    w_bit_cin;
  logic [W-1:0]    w_sum;
  logic            w_c_msb;
  logic            w_cout;
  logic            w_ovf;
  logic            w_unused;

  // Handshake: a full output register frees up only when the consumer takes it.
  assign w_adv2    = !r_out_valid || out_ready;
  assign w_adv1    = !r_s1_valid || w_adv2;
  assign in_ready  = w_adv1;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

  // Stage 1 combinational: effective operand, per-bit g/p and per-block group G/P.
  always_comb begin
    gp_t acc_v;
    w_b_eff   = sub ? ~b : b;
    w_cin_eff = sub ? 1'b1 : cin;
    w_g       = a & w_b_eff;
    w_p       = a ^ w_b_eff;
    w_gp      = '0;
    for (int k = 0; k < NB; k++) begin
      acc_v = '{g: 1'b0, p: 1'b1};
      for (int j = 0; j < B; j++) begin
        acc_v = gp_combine(gp_t'({w_g[k*B+j], w_p[k*B+j]}), acc_v);
      end
      w_gp[k] = acc_v;
    end
  end

  // Stage 1 register: loads on advance, holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_b_eff    <= '0;
      r_cin_eff  <= 1'b0;
      r_g        <= '0;
      r_p        <= '0;
      r_gp       <= '0;
      r_a_msb    <= 1'b0;
      r_b_msb    <= 1'b0;
    end else if (w_adv1) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_b_eff   <= w_b_eff;
        r_cin_eff <= w_cin_eff;
        r_g       <= w_g;
        r_p       <= w_p;
        r_gp      <= w_gp;
        r_a_msb   <= a[W-1];
        r_b_msb   <= w_b_eff[W-1];
      end
    end
  end

  // Stage 2 lookahead across blocks: c[k+1] = G[k] | P[k] & c[k].
  always_comb begin
    logic c_v;
    c_v        = r_cin_eff;
    w_blk_c    = '0;
    w_blk_c[0] = c_v;
    for (int k = 0; k < NB; k++) begin
      c_v          = r_gp[k].g | (r_gp[k].p & c_v);
      w_blk_c[k+1] = c_v;
    end
  end

  for (genvar k = 0; k < NB; k++) begin : g_blk
    cla_block #(.B(B)) u_cla_block (
      .i_g    (r_g[k*B +: B]),
      .i_p    (r_p[k*B +: B]),
      .i_c_in (w_blk_c[k]),
      .o_gp   (w_gp_s2[k]),
      .o_c    (w_bit_cout[k*B +: B])
    );
  end

  // Carry into each bit: block carry-in at a block boundary, otherwise the bit below.
  for (genvar i = 0; i < W; i++) begin : g_cin
    if ((i % B) == 0) begin : g_edge
      assign w_bit_cin[i] = w_blk_c[i/B];
    end else begin : g_inner
      assign w_bit_cin[i] = w_bit_cout[i-1];
    end
  end

  // cout is rebuilt from the registered MSB operands and the carry into the MSB.
  assign w_sum   = r_p ^ w_bit_cin;
  assign w_c_msb = w_bit_cin[W-1];
  assign w_cout  = (r_a_msb & r_b_msb) | ((r_a_msb ^ r_b_msb) & w_c_msb);
  assign w_ovf   = w_c_msb ^ w_cout;

  // Redundant views (block G/P recomputed in stage 2, last carries) are intentionally unused.
  assign w_unused = ^{r_b_eff, w_gp_s2, w_bit_cout, w_blk_c};

  // Stage 2 register: result is held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (w_adv2) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_sum  <= w_sum;
        r_cout <= w_cout;
        r_ovf  <= w_ovf;
      end
    end
  end

endmodule
